// File: rtl/button_debounce_bank.sv
// button_debounce_bank
//   A bank of N_CH independent debouncers for active-low mechanical buttons. Each raw
//   input is brought in through a 2-flop synchronizer. A per-channel 4-state FSM then
//   accepts a level change only after STABLE_CNT consecutive stable samples. All
//   outputs are registered.
//
// Build option:
//   DEBOUNCE_REPEAT_EN - when defined, a held button emits extra o_press pulses: the
//                        first after REPEAT_DELAY held cycles, then one every
//                        REPEAT_RATE cycles. Undefined: one o_press per accepted press.
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous reset, active-low
//   i_btn_n      raw asynchronous buttons, active-low (0 = pressed)
//   o_level      debounced level per channel, active-high
//   o_press      one-cycle pulse per accepted press (and per auto-repeat when enabled)
//   o_release    one-cycle pulse per accepted release
//   o_any_press  OR of o_press, same cycle
module button_debounce_bank #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned STABLE_CNT   = 500000,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [N_CH-1:0] i_btn_n,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic            o_any_press
);

  typedef enum logic [1:0] {StIdle, StPressWait, StPressed, StReleaseWait} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(STABLE_CNT - 1);

  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [N_CH-1:0] press_pend_vec;
  logic [N_CH-1:0] level_vec, press_vec, release_vec;
  logic            any_press_q;

  // Synchronizer flops reset to 1 so a reset reads as "all buttons released".
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= i_btn_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, release_evt, rep_fire;
    logic             press_pend_q, release_pend_q;
    logic             level_q, press_q, release_q;
    logic             btn_up;

    assign btn_up = sync2_q[gi];

    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      accept      = 1'b0;
      release_evt = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!btn_up) begin
            state_d = StPressWait;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        StPressWait: begin
          // A bounce wins over the final count: the press is only taken if the
          // input is still low on the qualifying cycle.
          if (btn_up) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == LastCnt) begin
            state_d = StPressed;
            cnt_d   = '0;
            accept  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StPressed: begin
          if (btn_up) begin
            state_d = StReleaseWait;
            cnt_d   = CNT_W'(1);
          end
        end
        StReleaseWait: begin
          if (!btn_up) begin
            state_d = StPressed;
            cnt_d   = '0;
          end else if (cnt_q == LastCnt) begin
            state_d     = StIdle;
            cnt_d       = '0;
            release_evt = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                                  : REPEAT_RATE;
    localparam int unsigned RepW   = $clog2(RepMax) + 1;

    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep_on_q, rep_on_d;

    // Counts only on cycles that stay in PRESSED; any other cycle (entry, release
    // wait, return from release wait) restarts the sequence at REPEAT_DELAY.
    always_comb begin
      rep_cnt_d = '0;
      rep_on_d  = 1'b0;
      rep_fire  = 1'b0;
      if (state_q == StPressed && state_d == StPressed) begin
        rep_on_d = rep_on_q;
        if ((!rep_on_q && rep_cnt_q == RepW'(REPEAT_DELAY - 1)) ||
            (rep_on_q && rep_cnt_q == RepW'(REPEAT_RATE - 1))) begin
          rep_fire  = 1'b1;
          rep_cnt_d = '0;
          rep_on_d  = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + RepW'(1);
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_reset) begin
        rep_cnt_q <= '0;
        rep_on_q  <= 1'b0;
      end else begin
        rep_cnt_q <= rep_cnt_d;
        rep_on_q  <= rep_on_d;
      end
    end
`else
    logic unused_rep;
    assign unused_rep = ^{REPEAT_DELAY, REPEAT_RATE};
    assign rep_fire   = 1'b0;
`endif

    // Events are staged one cycle so the pulse lands in the cycle after the
    // transition, matching the 2 + STABLE_CNT press latency.
    always_ff @(posedge i_clk) begin
      if (!i_reset) begin
        state_q        <= StIdle;
        cnt_q          <= '0;
        press_pend_q   <= 1'b0;
        release_pend_q <= 1'b0;
        level_q        <= 1'b0;
        press_q        <= 1'b0;
        release_q      <= 1'b0;
      end else begin
        state_q        <= state_d;
        cnt_q          <= cnt_d;
        press_pend_q   <= accept | rep_fire;
        release_pend_q <= release_evt;
        level_q        <= (state_d == StPressed) || (state_d == StReleaseWait);
        press_q        <= press_pend_q;
        release_q      <= release_pend_q;
      end
    end

    assign press_pend_vec[gi] = press_pend_q;
    assign level_vec[gi]      = level_q;
    assign press_vec[gi]      = press_q;
    assign release_vec[gi]    = release_q;
  end

  // Built from the same staged events as o_press so both rise in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_pend_vec;
    end
  end

  assign o_level     = level_vec;
  assign o_press     = press_vec;
  assign o_release   = release_vec;
  assign o_any_press = any_press_q;

endmodule

// File: tb/tb_button_debounce_bank.sv
// Testbench for button_debounce_bank (N_CH=4, STABLE_CNT=4, REPEAT_DELAY=10,
// REPEAT_RATE=3). Expected outputs come from an acceptance model: a level flips
// after STABLE_CNT consecutive synchronized samples disagree with it, and each
// accepted change is reported one cycle later.
module tb_button_debounce_bank;

  localparam int unsigned NCh      = 4;
  localparam int unsigned Stable   = 4;
  localparam int unsigned RepDelay = 10;
  localparam int unsigned RepRate  = 3;
`ifdef DEBOUNCE_REPEAT_EN
  localparam bit RepEn = 1'b1;
`else
  localparam bit RepEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCh-1:0] btn_n = '1;
  logic [NCh-1:0] level, press, rel;
  logic           any;

  always #5 clk = ~clk;

  button_debounce_bank #(
    .N_CH        (NCh),
    .CNT_W       (8),
    .STABLE_CNT  (Stable),
    .REPEAT_DELAY(RepDelay),
    .REPEAT_RATE (RepRate)
  ) u_dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_btn_n    (btn_n),
    .o_level    (level),
    .o_press    (press),
    .o_release  (rel),
    .o_any_press(any)
  );

  logic [3*NCh:0] obs_v, exp_v;
  assign obs_v = {level, press, rel, any};

  // Model state
  logic [NCh-1:0] m_s1 = '1, m_s2 = '1, m_level = '0, m_pend_p = '0, m_pend_r = '0;
  int             m_run[NCh];
  int             m_held[NCh];

  int n_checks = 0;
  int n_pass   = 0;

  // Advance one clock and update the model with the inputs seen at that edge.
  task automatic step();
    logic           r;
    logic [NCh-1:0] b;
    logic [NCh-1:0] e_p, e_r;
    logic           pr;
    r = rst_n;
    b = btn_n;
    @(posedge clk);
    #1;
    if (!r) begin
      m_s1 = '1; m_s2 = '1; m_level = '0; m_pend_p = '0; m_pend_r = '0;
      for (int c = 0; c < NCh; c++) begin
        m_run[c]  = 0;
        m_held[c] = 0;
      end
      exp_v = '0;
    end else begin
      e_p = m_pend_p;
      e_r = m_pend_r;
      for (int c = 0; c < NCh; c++) begin
        pr          = ~m_s2[c];
        m_pend_p[c] = 1'b0;
        m_pend_r[c] = 1'b0;
        if (pr == m_level[c]) begin
          if (m_level[c] && m_run[c] == 0) begin
            m_held[c]++;
            if (RepEn && (m_held[c] == RepDelay ||
                (m_held[c] > RepDelay && (m_held[c] - RepDelay) % RepRate == 0)))
              m_pend_p[c] = 1'b1;
          end else begin
            m_held[c] = 0;
          end
          m_run[c] = 0;
        end else begin
          m_held[c] = 0;
          m_run[c]++;
          if (m_run[c] == Stable) begin
            m_level[c] = pr;
            m_run[c]   = 0;
            if (pr) m_pend_p[c] = 1'b1;
            else    m_pend_r[c] = 1'b1;
          end
        end
      end
      m_s2  = m_s1;
      m_s1  = b;
      exp_v = {m_level, e_p, e_r, |e_p};
    end
  endtask

  task automatic settle(input int n);
    btn_n = '1;
    rst_n = 1'b1;
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      btn_n = 4'($urandom);
      step();
      n_checks++;
      if (obs_v !== 13'h0) $display("FAIL reset_outputs got %h want 0", obs_v);
      else n_pass++;
    end
    rst_n = 1'b1;
    btn_n = '1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL reset_idle got %h want %h", obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    int lat = -1;
    int np  = 0;
    int want_np;
    want_np = RepEn ? 3 : 1;
    btn_n[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL clean_model k=%0d got %h want %h", k, obs_v, exp_v);
      else n_pass++;
      if (press[0]) begin
        np++;
        if (lat < 0) begin
          lat = k;
          n_checks++;
          if ({level[0], any} !== 2'b11)
            $display("FAIL clean_level_any got %b want 11", {level[0], any});
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (lat !== 6) $display("FAIL clean_latency got %0d want 6", lat);
    else n_pass++;
    n_checks++;
    if (np !== want_np) $display("FAIL clean_count got %0d want %0d", np, want_np);
    else n_pass++;
    settle(12);
  endtask

  task automatic test_bounce();
    logic seen_p = 1'b0;
    logic seen_l = 1'b0;
    for (int k = 0; k < 13; k++) begin
      btn_n[1] = (k < 3) ? 1'b0 : 1'b1;
      step();
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL bounce_model k=%0d got %h want %h", k, obs_v, exp_v);
      else n_pass++;
      seen_p |= press[1];
      seen_l |= level[1];
    end
    n_checks++;
    if ({seen_p, seen_l} !== 2'b00)
      $display("FAIL bounce_ignored got %b want 00", {seen_p, seen_l});
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int pk = -1;
    int rk = -1;
    btn_n = 4'b0110;
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL simul_press_model got %h want %h", obs_v, exp_v);
      else n_pass++;
      if (pk < 0 && press == 4'b1001) pk = k;
    end
    btn_n = '1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL simul_rel_model got %h want %h", obs_v, exp_v);
      else n_pass++;
      if (rk < 0 && rel == 4'b1001) rk = k;
    end
    n_checks++;
    if (pk !== 6) $display("FAIL simul_press_cycle got %0d want 6", pk);
    else n_pass++;
    n_checks++;
    if (rk !== 6) $display("FAIL simul_release_cycle got %0d want 6", rk);
    else n_pass++;
    settle(4);
  endtask

  task automatic test_reset_mid();
    int pk = -1;
    btn_n[2] = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if (obs_v !== 13'h0) $display("FAIL midreset_outputs got %h want 0", obs_v);
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL midreset_model got %h want %h", obs_v, exp_v);
      else n_pass++;
      if (pk < 0 && press[2]) pk = k;
    end
    n_checks++;
    if (pk !== 6) $display("FAIL midreset_press_cycle got %0d want 6", pk);
    else n_pass++;
    settle(12);
  endtask

  task automatic test_repeat();
    int np = 0;
    int want_np;
    want_np = RepEn ? 8 : 1;
    btn_n[0] = 1'b0;
    for (int k = 0; k < 37; k++) begin
      step();
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL repeat_model k=%0d got %h want %h", k, obs_v, exp_v);
      else n_pass++;
      if (press[0]) np++;
    end
    n_checks++;
    if (np !== want_np) $display("FAIL repeat_count got %0d want %0d", np, want_np);
    else n_pass++;
    settle(12);
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < NCh; c++)
        if ($urandom_range(0, 5) == 0) btn_n[c] = ~btn_n[c];
      rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      step();
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL random_model k=%0d got %h want %h", k, obs_v, exp_v);
      else n_pass++;
    end
    settle(12);
  endtask

  initial begin
    for (int c = 0; c < NCh; c++) begin
      m_run[c]  = 0;
      m_held[c] = 0;
    end
    exp_v = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_repeat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
